// File: rtl/signed_add_rr_scheduler_if.sv
// signed_add_rr_scheduler_if: requester operand bus and result stage handshake
interface signed_add_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W = 4
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic res_valid;
  logic res_ready;
  logic [W-1:0] res_sum;
  logic res_overflow;
  logic [$clog2(N_REQ)-1:0] res_id;
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input req_ready, res_valid, res_sum, res_overflow, res_id
  );
  modport slave (
    input req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_overflow, res_id
  );
endinterface

// File: rtl/signed_add_rr_scheduler.sv
// signed_add_rr_scheduler: round-robin shared signed adder with registered result and overflow counter
module signed_add_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int W = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  signed_add_rr_scheduler_if.slave bus,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, grant;
  logic found, free, xfer, ovf;
  logic [W-1:0] a, b, s;
  // search downward so the requester closest above ptr is assigned last and wins
  always_comb begin
    found = 1'b0;
    grant = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        grant = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
  assign free = !bus.res_valid | bus.res_ready;
  assign xfer = found & free & !rst;
  assign bus.req_ready = xfer ? N_REQ'(1) << grant : '0;
  assign a = bus.req_a[grant*W +: W];
  assign b = bus.req_b[grant*W +: W];
  assign s = a + b;
  assign ovf = (a[W-1] & b[W-1] & ~s[W-1]) | (~a[W-1] & ~b[W-1] & s[W-1]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_sum <= '0;
      bus.res_overflow <= 1'b0;
      bus.res_id <= '0;
      ovf_count <= '0;
      ptr <= '0;
    end else begin
      if (bus.res_valid & bus.res_ready & bus.res_overflow & ~&ovf_count)
        ovf_count <= ovf_count + 1'b1;
      if (xfer) begin
        bus.res_valid <= 1'b1;
        bus.res_sum <= s;
        bus.res_overflow <= ovf;
        bus.res_id <= grant;
        ptr <= (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_signed_add_rr_scheduler.sv
// tb_signed_add_rr_scheduler: randomized and directed scoreboard bench for the shared adder scheduler
module tb_signed_add_rr_scheduler;
  localparam int N = 4;
  localparam int W = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {int sum; int ovf; int id;} item_t;
  logic clk = 0;
  logic rst = 1;
  logic [CW-1:0] ovf_count;
  signed_add_rr_scheduler_if #(.N_REQ(N), .W(W)) bus ();
  signed_add_rr_scheduler #(.N_REQ(N), .W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  item_t q[$];
  item_t pend_item;
  int checks = 0, errors = 0;
  int ptr = 0, exp_cnt = 0;
  bit mvalid = 0, pending = 0;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask
  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic rdy);
    int g, t;
    @(posedge clk);
    if (pending) q.push_back(pend_item);
    pending = 0;
    #1;
    bus.req_valid = v;
    bus.req_a = a;
    bus.req_b = b;
    bus.res_ready = rdy;
    #1;
    g = -1;
    if (!mvalid || rdy)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    chk("req_ready", int'(bus.req_ready), g >= 0 ? (1 << g) : 0);
    if (g >= 0) begin
      t = sx(a[g*W +: W]) + sx(b[g*W +: W]);
      pend_item.sum = t & ((1 << W) - 1);
      pend_item.ovf = (t > (1 << (W - 1)) - 1 || t < -(1 << (W - 1))) ? 1 : 0;
      pend_item.id = g;
      pending = 1;
      ptr = (g + 1) % N;
    end
    mvalid = (g >= 0) || (mvalid && !rdy);
  endtask
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("res_valid", int'(bus.res_valid), q.size() != 0 ? 1 : 0);
        chk("ovf_count", int'(ovf_count), exp_cnt);
        if (bus.res_valid && bus.res_ready && q.size() != 0) begin
          it = q.pop_front();
          chk("res_sum", int'(bus.res_sum), it.sum);
          chk("res_overflow", int'(bus.res_overflow), it.ovf);
          chk("res_id", int'(bus.res_id), it.id);
          if (it.ovf != 0 && exp_cnt < CMAX) exp_cnt++;
        end
      end
    end
  end
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;
    #1;
    chk("rst_valid", int'(bus.res_valid), 0);
    chk("rst_count", int'(ovf_count), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    @(negedge clk);
    rst = 0;
    step(4'b0100, 16'h0700, 16'h0100, 1);
    step('0, '0, '0, 1);
    step(4'b0001, 16'h0008, 16'h000f, 1);
    step(4'b0001, 16'h000c, 16'h0003, 1);
    step('0, '0, '0, 1);
    for (int i = 0; i < 8; i++) step(4'b1111, 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 3; i++) step(4'b1111, 16'($urandom), 16'($urandom), 0);
    step(4'b1111, 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 10; i++) step(4'b1111, 16'h7777, 16'h1111, 1);
    step(4'b0100, 16'h0300, 16'h0200, 1);
    step('0, '0, '0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_valid", int'(bus.res_valid), 0);
    chk("arst_sum", int'(bus.res_sum), 0);
    chk("arst_ovf", int'(bus.res_overflow), 0);
    chk("arst_id", int'(bus.res_id), 0);
    chk("arst_count", int'(ovf_count), 0);
    chk("arst_ready", int'(bus.req_ready), 0);
    q.delete();
    pending = 0;
    mvalid = 0;
    ptr = 0;
    exp_cnt = 0;
    @(posedge clk);
    #3;
    rst = 0;
    step(4'b1111, 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("drained", q.size() + (pending ? 1 : 0), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
